// File: rtl/apb3_cmd_master_if.sv
// Command/response stream plus APB3 request/completion bundle for apb3_cmd_master.
interface apb3_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [31:0]           PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb3_cmd_master.sv
// Single-outstanding APB3 master: one command in, one SETUP/ACCESS transfer, one response out.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb3_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               PCLK,
  input logic               PRESET,
  apb3_cmd_master_if.master bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      StAccess: begin
        // Completion is checked first so PREADY in the final allowed cycle still wins.
        if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? 32'h0 : bus.PRDATA;
          state_d       = StResp;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 32'h0;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Self-checking bench for apb3_cmd_master: directed table, reset corner cases, random traffic.
module tb_apb3_cmd_master;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb3_cmd_master_if #(.ADDR_WIDTH(AW)) u_if ();

  apb3_cmd_master #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (u_if.master)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;   // PREADY-low ACCESS cycles before completion
    logic [31:0] prdata;
    logic        slverr;
    int          stall;    // cycles rsp_ready is held low in RESP
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int wait_n, input logic [31:0] prdata, input logic slverr,
                              input int stall, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic exp_to);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.wait_n = wait_n; v.prdata = prdata;
    v.slverr = slverr; v.stall = stall; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_to = exp_to;
    return v;
  endfunction

  function automatic bit times_out(input int wait_n);
`ifdef APB_MASTER_TIMEOUT_EN
    return wait_n >= int'(TO);
`else
    return 1'b0;
`endif
  endfunction

  // Number of cycles PSEL&PENABLE must be seen for a given slave wait count.
  function automatic int model_acc(input int wait_n);
    return times_out(wait_n) ? int'(TO) : wait_n + 1;
  endfunction

  function automatic vec_t with_expect(input vec_t v);
    vec_t r = v;
    bit   t = times_out(v.wait_n);
    r.exp_to    = t;
    r.exp_err   = t | v.slverr;
    r.exp_rdata = (t || v.wr) ? 32'h0 : v.prdata;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, u_if.cmd_ready, 0);
    chk({tag, "_rsp_valid"}, u_if.rsp_valid, 0);
    chk({tag, "_psel"}, u_if.PSEL, 0);
    chk({tag, "_penable"}, u_if.PENABLE, 0);
    chk({tag, "_pwrite"}, u_if.PWRITE, 0);
    chk({tag, "_paddr"}, u_if.PADDR, 0);
    chk({tag, "_pwdata"}, u_if.PWDATA, 0);
    chk({tag, "_rsp_rdata"}, u_if.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, u_if.rsp_err, 0);
    chk({tag, "_rsp_timeout"}, u_if.rsp_timeout, 0);
  endtask

  // Entered and left at a negedge with the master idle.
  task automatic xfer(input vec_t v);
    int acc;
    chk("idle_cmd_ready", u_if.cmd_ready, 1);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = v.wr;
    u_if.cmd_addr  = v.addr;
    u_if.cmd_wdata = v.wdata;
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    u_if.cmd_write = ~v.wr;
    u_if.cmd_addr  = $urandom;
    u_if.cmd_wdata = $urandom;
    chk("setup_psel", u_if.PSEL, 1);
    chk("setup_penable", u_if.PENABLE, 0);
    chk("setup_cmd_ready", u_if.cmd_ready, 0);
    chk("setup_paddr", u_if.PADDR, v.addr);
    chk("setup_pwdata", u_if.PWDATA, v.wdata);
    chk("setup_pwrite", u_if.PWRITE, v.wr);
    // PREADY during SETUP must not complete the transfer
    u_if.PREADY  = 1'b1;
    u_if.PRDATA  = 32'hBAD0BAD0;
    u_if.PSLVERR = 1'b1;
    @(negedge clk);
    acc = 0;
    while (u_if.PSEL && u_if.PENABLE && acc < 200) begin
      acc++;
      chk("access_paddr", u_if.PADDR, v.addr);
      chk("access_pwdata", u_if.PWDATA, v.wdata);
      chk("access_pwrite", u_if.PWRITE, v.wr);
      if (acc > v.wait_n) begin
        u_if.PREADY  = 1'b1;
        u_if.PRDATA  = v.prdata;
        u_if.PSLVERR = v.slverr;
      end else begin
        u_if.PREADY  = 1'b0;
        u_if.PRDATA  = $urandom;
        u_if.PSLVERR = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    u_if.PREADY  = 1'b0;
    u_if.PSLVERR = 1'b0;
    u_if.PRDATA  = $urandom;
    chk("access_cycles", acc, model_acc(v.wait_n));
    chk("resp_psel", u_if.PSEL, 0);
    chk("resp_penable", u_if.PENABLE, 0);
    chk("resp_valid", u_if.rsp_valid, 1);
    chk("resp_rdata", u_if.rsp_rdata, v.exp_rdata);
    chk("resp_err", u_if.rsp_err, v.exp_err);
    chk("resp_timeout", u_if.rsp_timeout, v.exp_to);
    chk("resp_cmd_ready", u_if.cmd_ready, 0);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("hold_valid", u_if.rsp_valid, 1);
      chk("hold_rdata", u_if.rsp_rdata, v.exp_rdata);
      chk("hold_err", u_if.rsp_err, v.exp_err);
      chk("hold_timeout", u_if.rsp_timeout, v.exp_to);
      chk("hold_cmd_ready", u_if.cmd_ready, 0);
    end
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    u_if.rsp_ready = 1'b0;
    chk("post_rsp_valid", u_if.rsp_valid, 0);
    chk("post_cmd_ready", u_if.cmd_ready, 1);
    chk("post_psel", u_if.PSEL, 0);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h20, 32'h12345678, 3, 32'hFFFFFFFF, 1'b0, 0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h30, 32'h0, 1, 32'hCAFE0001, 1'b1, 5, 32'hCAFE0001, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 32'h44, 32'hA5A5A5A5, 0, 32'h77777777, 1'b1, 2, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 32'h50, 32'h0, 3, 32'h0BADF00D, 1'b0, 0, 32'h0BADF00D, 1'b0, 1'b0));
`ifdef APB_MASTER_TIMEOUT_EN
    tbl.push_back(mk(1'b0, 32'h60, 32'h0, 10, 32'h11112222, 1'b0, 1, 32'h0, 1'b1, 1'b1));
`else
    tbl.push_back(mk(1'b0, 32'h60, 32'h0, 10, 32'h11112222, 1'b0, 1, 32'h11112222, 1'b0, 1'b0));
`endif

    u_if.cmd_valid = 1'b0;
    u_if.cmd_write = 1'b0;
    u_if.cmd_addr  = '0;
    u_if.cmd_wdata = '0;
    u_if.rsp_ready = 1'b0;
    u_if.PREADY    = 1'b0;
    u_if.PSLVERR   = 1'b0;
    u_if.PRDATA    = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("release_cmd_ready", u_if.cmd_ready, 1);

    foreach (tbl[i]) xfer(tbl[i]);

    // Reset while in ACCESS: everything returns to reset values, no response follows.
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = 1'b1;
    u_if.cmd_addr  = 32'h88;
    u_if.cmd_wdata = 32'h55AA55AA;
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    u_if.PREADY    = 1'b0;
    @(negedge clk);
    chk("mid_in_access", {u_if.PSEL, u_if.PENABLE}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_release_cmd_ready", u_if.cmd_ready, 1);
    chk("mid_release_rsp_valid", u_if.rsp_valid, 0);
    chk("mid_release_psel", u_if.PSEL, 0);
    xfer(tbl[0]);

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.wait_n = $urandom_range(0, 6);
      v.prdata = $urandom;
      v.slverr = 1'($urandom_range(0, 1));
      v.stall  = $urandom_range(0, 3);
      xfer(with_expect(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/apb3_cmd_master.md
# apb3_cmd_master

Single-outstanding APB3 master that converts a valid/ready command stream into APB3 SETUP/ACCESS transfers. It drives PADDR/PSEL/PENABLE/PWRITE/PWDATA into the slave address decoder. It consumes the decoder's muxed PREADY/PSLVERR/PRDATA and returns one response per command. An optional access-phase timeout lets the bus abort on an unresponsive slave.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of cmd_addr and PADDR.
- TIMEOUT_CYCLES, 256: ACCESS cycles allowed before abort; legal range 2..65535; used only when the timeout macro is defined.

Ports:
- PCLK  in  1  sole clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_WIDTH, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  32: APB3 request.
- PREADY  in  1, PSLVERR  in  1, PRDATA  in  32: muxed APB3 completion.

## Operation
- All outputs are registered.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch write/addr/wdata → SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. On PREADY=1, capture PSLVERR, and PRDATA if read; drop PSEL/PENABLE → RESP. Without PREADY, stay in ACCESS.
  - RESP: rsp_valid=1 with rsp_rdata/rsp_err/rsp_timeout held stable. On rsp_ready=1 → IDLE.
- cmd_ready is 0 in every state except IDLE. At most one transfer is outstanding.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the final ACCESS cycle. Between transfers they keep their last values.
- PRDATA and PSLVERR are ignored whenever PENABLE=0 or PREADY=0.
- Reset values: cmd_ready=0, rsp_valid=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, state IDLE. cmd_ready rises on the first edge after PRESET deasserts.
- Reset mid-transfer: the next edge forces every output to its reset value. No response is issued for the aborted command.
- PREADY high in SETUP is ignored.

## Timing
- Minimum latency:
  - cycle 0: command accepted.
  - cycle 1: SETUP.
  - cycle 2: ACCESS, with PREADY=1 sampled.
  - cycle 3: rsp_valid=1, PSEL=0.
  - cycle 4 earliest: rsp_ready accepted in cycle 3 → IDLE with cmd_ready=1.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Earliest next SETUP is 2 cycles after the response handshake.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - If PREADY is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the master drops PSEL/PENABLE and enters RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in that same cycle completes normally (completion wins).
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter. ACCESS waits indefinitely.
  - rsp_timeout is tied 0.

## Test plan
- Read 0x0000_0010, PREADY=1 immediately, PRDATA=0xDEADBEEF → PSEL rises cycle 1, PENABLE cycle 2; rsp_valid cycle 3 with rdata=0xDEADBEEF, err=0.
- Write 0x0000_0020 data 0x12345678, PREADY low 3 ACCESS cycles → PADDR/PWDATA stable for all 4 ACCESS cycles; rsp rdata=0, err=0 at cycle 6.
- Read with PSLVERR=1 at completion, rsp_ready low 5 cycles → rsp_err=1, rsp_valid held with fields stable; cmd_ready=0 until handshake.
- Timeout enabled, TIMEOUT_CYCLES=4, PREADY never asserted → exactly 4 ACCESS cycles; then PSEL=0, rsp_err=1, rsp_timeout=1. Repeat with PREADY=1 on the 4th ACCESS cycle → normal completion, rsp_timeout=0.
- PRESET pulsed during ACCESS → all outputs 0 next edge, no rsp_valid. The following command completes normally with cmd_ready=1 one cycle after reset release.
